// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-serial load/store unit: ctrl codes, FSM states,
// access size and request legality helpers.
package lsu_pkg;

  localparam logic [2:0] CTRL_LB  = 3'b000;
  localparam logic [2:0] CTRL_LH  = 3'b001;
  localparam logic [2:0] CTRL_LW  = 3'b010;
  localparam logic [2:0] CTRL_LBU = 3'b100;
  localparam logic [2:0] CTRL_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    RESP
  } state_t;

  // Byte count from the size field; only 010 reaches the word case when legal.
  function automatic logic [2:0] byte_count(input logic [2:0] ctrl);
    case (ctrl[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic req_legal(input logic [2:0] ctrl, input logic we);
    case (ctrl)
      CTRL_LB, CTRL_LH, CTRL_LW: return 1'b1;
      CTRL_LBU, CTRL_LHU:        return !we;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load data extension: sign/zero-extends an assembled little-endian load by ctrl.
// Purely combinational; no latency, no flow control.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  ctrl,
  input  logic [31:0] asm_data,
  output logic [31:0] rdata
);

  always_comb begin
    rdata = '0;
    case (ctrl)
      CTRL_LB:  rdata = {{24{asm_data[7]}}, asm_data[7:0]};
      CTRL_LH:  rdata = {{16{asm_data[15]}}, asm_data[15:0]};
      CTRL_LW:  rdata = asm_data;
      CTRL_LBU: rdata = {24'h0, asm_data[7:0]};
      CTRL_LHU: rdata = {16'h0, asm_data[15:0]};
      default:  rdata = '0;
    endcase
  end

endmodule

// File: rtl/lsu_byte_master.sv
// Byte-serial load/store initiator: N byte accesses, response N+1 cycles after accept (error: 1).
// One request at a time via req_ready; no response backpressure. LSU_MISALIGN_TRAP_EN traps misaligned half/word.
module lsu_byte_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_ctrl,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       asm_q;
  logic [2:0]        ctrl_q;
  logic              we_q;
  logic [1:0]        cnt;

  logic [1:0]        cnt_nxt;
  logic              last;
  logic              req_ok;
  logic [31:0]       asm_nxt;
  logic [31:0]       ext_data;

  assign cnt_nxt = cnt + 2'd1;
  assign last    = ({1'b0, cnt} == byte_count(ctrl_q) - 3'd1);

  // Assembly including the byte arriving this cycle, so the final byte extends without a bubble.
  always_comb begin
    asm_nxt = asm_q;
    asm_nxt[{cnt, 3'b000} +: 8] = mem_rdata;
  end

  always_comb begin
    req_ok = req_legal(req_ctrl, req_we);
`ifdef LSU_MISALIGN_TRAP_EN
    if (req_ctrl[1:0] == 2'b01 && req_addr[0])
      req_ok = 1'b0;
    if (req_ctrl == CTRL_LW && req_addr[1:0] != 2'b00)
      req_ok = 1'b0;
`endif
  end

  lsu_extend u_extend (
    .ctrl     (ctrl_q),
    .asm_data (asm_nxt),
    .rdata    (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      asm_q     <= '0;
      ctrl_q    <= '0;
      we_q      <= 1'b0;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            ctrl_q    <= req_ctrl;
            we_q      <= req_we;
            cnt       <= '0;
            asm_q     <= '0;
            req_ready <= 1'b0;
            if (req_ok) begin
              state     <= XFER;
              mem_addr  <= req_addr;
              mem_re    <= !req_we;
              mem_we    <= req_we;
              mem_wdata <= req_we ? req_wdata[7:0] : 8'h00;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        XFER: begin
          if (!we_q)
            asm_q <= asm_nxt;
          if (last) begin
            state     <= RESP;
            mem_addr  <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= we_q ? 32'h0 : ext_data;
          end else begin
            cnt       <= cnt_nxt;
            mem_addr  <= addr_q + ADDR_W'(cnt_nxt);
            mem_wdata <= we_q ? wdata_q[{cnt_nxt, 3'b000} +: 8] : 8'h00;
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_byte_master.sv
// Bench for lsu_byte_master: directed vector table, reset-abort sequence and
// randomized traffic checked against a byte-array reference model.
module tb_lsu_byte_master;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_ctrl = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  lsu_byte_master #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_ctrl  (req_ctrl),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory seen by the DUT (1 KiB, aliased) and a log of every write strobe.
  logic [7:0]  mem [0:1023];
  logic [7:0]  ref_mem [0:1023];
  logic        mem_clr = 1'b1;
  logic [31:0] wlog_a[$];
  logic [7:0]  wlog_d[$];
  int          nreads = 0;
  int          nrsp = 0;
  int          nboth = 0;

  assign mem_rdata = mem[mem_addr[9:0]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[mem_addr[9:0]] <= mem_wdata;
    end
    if (mem_we) begin
      wlog_a.push_back(mem_addr);
      wlog_d.push_back(mem_wdata);
    end
    if (mem_re) nreads <= nreads + 1;
    if (rsp_valid) nrsp <= nrsp + 1;
    if (mem_re && mem_we) nboth <= nboth + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  // Reference model: legality, size and load value straight from the access rules.
  function automatic bit m_legal(input logic we, input logic [2:0] c, input logic [31:0] a);
    bit ok;
    ok = (c == 3'b000 || c == 3'b001 || c == 3'b010) ||
         (!we && (c == 3'b100 || c == 3'b101));
    if (MIS && (c == 3'b001 || c == 3'b101) && (a % 2 != 0)) ok = 1'b0;
    if (MIS && c == 3'b010 && (a % 4 != 0)) ok = 1'b0;
    return ok;
  endfunction

  function automatic int m_nbytes(input logic [2:0] c);
    if (c == 3'b010) return 4;
    if (c == 3'b001 || c == 3'b101) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] c, input logic [31:0] a);
    logic [31:0] v;
    logic [31:0] ak;
    v = 0;
    for (int k = 0; k < m_nbytes(c); k++) begin
      ak = a + k;
      v = v + (32'(ref_mem[ak[9:0]]) << (8 * k));
    end
    if (c == 3'b000 && v >= 128) return v - 32'd256;
    if (c == 3'b001 && v >= 32768) return v - 32'd65536;
    return v;
  endfunction

  task automatic txn(input logic we, input logic [2:0] c, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_rd,
                     input logic exp_err, input int exp_lat, input string nm);
    int w0, r0, g, lat, n, exp_nw, exp_nr;
    logic [31:0] rd, ak;
    logic er;
    bit got, busy_ok, idle_ok;
    g = 0;
    @(negedge clk);
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk({nm, " ready"}, 32'(req_ready), 32'd1);
    w0 = wlog_a.size();
    r0 = nreads;
    req_valid = 1'b1; req_we = we; req_ctrl = c; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_ctrl = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    got = 0; busy_ok = 1; idle_ok = 0; lat = 99; rd = '0; er = 1'b0;
    for (int cyc = 1; cyc <= 10 && !got; cyc++) begin
      @(negedge clk);
      if (req_ready) busy_ok = 0;
      if (rsp_valid) begin
        got = 1; lat = cyc; rd = rsp_rdata; er = rsp_err;
        idle_ok = !mem_re && !mem_we && mem_addr == 0 && mem_wdata == 0;
      end
    end
    @(negedge clk);
    chk({nm, " after"}, {30'h0, rsp_valid, req_ready}, 32'h1);
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " rdata"}, rd, exp_rd);
    chk({nm, " err"}, 32'(er), 32'(exp_err));
    chk({nm, " busy"}, 32'(busy_ok), 32'd1);
    chk({nm, " idle_strobes"}, 32'(idle_ok), 32'd1);
    n = m_nbytes(c);
    exp_nw = (m_legal(we, c, a) && we) ? n : 0;
    exp_nr = (m_legal(we, c, a) && !we) ? n : 0;
    chk({nm, " nwrites"}, 32'(wlog_a.size() - w0), 32'(exp_nw));
    chk({nm, " nreads"}, 32'(nreads - r0), 32'(exp_nr));
    if (exp_nw > 0 && wlog_a.size() - w0 == exp_nw) begin
      for (int k = 0; k < n; k++) begin
        ak = a + k;
        chk($sformatf("%s waddr%0d", nm, k), wlog_a[w0 + k], ak);
        chk($sformatf("%s wdata%0d", nm, k), 32'(wlog_d[w0 + k]), 32'(wd[8*k +: 8]));
      end
    end
    if (exp_nw > 0) begin
      for (int k = 0; k < n; k++) begin
        ak = a + k;
        ref_mem[ak[9:0]] = wd[8*k +: 8];
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tv[$];
  logic [2:0] ctab [0:9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    int w0, rc0;
    logic [31:0] a, wd, exp_rd;
    logic we;
    logic [2:0] c;
    bit lg;

    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;

    tv.push_back('{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 5});
    tv.push_back('{1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 5});
    tv.push_back('{1'b1, 3'b000, 32'h20, 32'h00000080, 32'h0, 1'b0, 2});
    tv.push_back('{1'b0, 3'b000, 32'h20, 32'h0, 32'hFFFFFF80, 1'b0, 2});
    tv.push_back('{1'b0, 3'b100, 32'h20, 32'h0, 32'h00000080, 1'b0, 2});
    tv.push_back('{1'b1, 3'b001, 32'h40, 32'h00008001, 32'h0, 1'b0, 3});
    tv.push_back('{1'b0, 3'b001, 32'h40, 32'h0, 32'hFFFF8001, 1'b0, 3});
    tv.push_back('{1'b0, 3'b101, 32'h40, 32'h0, 32'h00008001, 1'b0, 3});
    tv.push_back('{1'b1, 3'b100, 32'h60, 32'h12, 32'h0, 1'b1, 1});
    tv.push_back('{1'b0, 3'b111, 32'h60, 32'h0, 32'h0, 1'b1, 1});
    tv.push_back('{1'b1, 3'b101, 32'h60, 32'h1234, 32'h0, 1'b1, 1});
    tv.push_back('{1'b0, 3'b011, 32'h60, 32'h0, 32'h0, 1'b1, 1});
    tv.push_back('{1'b0, 3'b110, 32'h60, 32'h0, 32'h0, 1'b1, 1});
    tv.push_back('{1'b1, 3'b010, 32'h202, 32'h11223344, 32'h0, MIS, MIS ? 1 : 5});
    tv.push_back('{1'b0, 3'b010, 32'h202, 32'h0, MIS ? 32'h0 : 32'h11223344, MIS, MIS ? 1 : 5});
    tv.push_back('{1'b1, 3'b010, 32'hFFFFFFFE, 32'hA1B2C3D4, 32'h0, MIS, MIS ? 1 : 5});
    tv.push_back('{1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, MIS ? 32'h0 : 32'hA1B2C3D4, MIS, MIS ? 1 : 5});
    tv.push_back('{1'b0, 3'b101, 32'h41, 32'h0, MIS ? 32'h0 : 32'h00000080, MIS, MIS ? 1 : 3});
    tv.push_back('{1'b1, 3'b000, 32'h103, 32'hFFFFFF5A, 32'h0, 1'b0, 2});
    tv.push_back('{1'b0, 3'b010, 32'h100, 32'h0, 32'h5AADBEEF, 1'b0, 5});

    // Reset state
    @(posedge clk);
    #1;
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_rdata", rsp_rdata, 32'd0);
    chk("rst rsp_err", 32'(rsp_err), 32'd0);
    chk("rst strobes", {30'h0, mem_re, mem_we}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", 32'(mem_wdata), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mem_clr = 1'b0;

    for (int i = 0; i < tv.size(); i++)
      txn(tv[i].we, tv[i].ctrl, tv[i].addr, tv[i].wdata, tv[i].exp_rdata,
          tv[i].exp_err, tv[i].exp_lat, $sformatf("vec%0d", i));

    // Reset asserted while byte 2 of a word store is on the bus.
    @(negedge clk);
    chk("abort ready", 32'(req_ready), 32'd1);
    w0 = wlog_a.size();
    rc0 = nrsp;
    req_valid = 1'b1; req_we = 1'b1; req_ctrl = 3'b010; req_addr = 32'h300; req_wdata = 32'h55667788;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort byte2 strobe", 32'(mem_we), 32'd1);
    chk("abort byte2 addr", mem_addr, 32'h302);
    rst = 1'b1;
    #1;
    chk("abort async drop", {30'h0, mem_re, mem_we}, 32'd0);
    chk("abort addr cleared", mem_addr, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort nwrites", 32'(wlog_a.size() - w0), 32'd2);
    if (wlog_a.size() - w0 == 2) begin
      chk("abort w0", {wlog_a[w0][23:0], wlog_d[w0]}, 32'h00030088);
      chk("abort w1", {wlog_a[w0 + 1][23:0], wlog_d[w0 + 1]}, 32'h00030177);
    end
    chk("abort no rsp", 32'(nrsp - rc0), 32'd0);
    chk("abort ready after", 32'(req_ready), 32'd1);
    ref_mem[10'h300] = 8'h88;
    ref_mem[10'h301] = 8'h77;

    // Randomized traffic against the reference model.
    ctab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111, 3'b010, 3'b001};
    for (int i = 0; i < 200; i++) begin
      c  = ctab[$urandom_range(0, 9)];
      we = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC + $urandom_range(0, 3) : $urandom_range(0, 1023);
      wd = $urandom;
      lg = m_legal(we, c, a);
      exp_rd = (lg && !we) ? m_load(c, a) : 32'h0;
      txn(we, c, a, wd, exp_rd, !lg, lg ? m_nbytes(c) + 1 : 1, $sformatf("rnd%0d", i));
    end

    chk("re_we exclusive", 32'(nboth), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
